perf_monitor: RTL and testbench



---
 rtl/perf_monitor.sv | 168 ++++++++++++++++
 tb/tb_perf_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : perf_monitor
//  Description : Multi-channel performance monitor. Counts CPU cycles and
//                NUM_EVENTS event strobes, detects end of program from the
//                PC and raises `finished` to gate the CPU clock. A registered
//                readout word presents one selected counter to the display.
//                The event strobe port is named `events` because `event` is a
//                reserved word in SystemVerilog.
//                Optional feature macro: PERF_TIMEOUT_EN (cycle-limit finish).
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_monitor #(
    parameter int              CNT_WIDTH      = 32,
    parameter int              NUM_EVENTS     = 4,
    parameter int              PC_WIDTH       = 16,
    parameter logic [63:0]     FINAL_PC       = 64'h01FF,
    parameter int              FINISH_HOLD    = 2,
    parameter int unsigned     TIMEOUT_CYCLES = 2**24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [3:0]            sel,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  finished,
    output logic                  timeout,
    output logic                  hold_active
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Final PC is zero-extended or truncated to the PC width.
    localparam logic [PC_WIDTH-1:0] c_final_pc = PC_WIDTH'(FINAL_PC);
    localparam int                  c_hold_w   = (FINISH_HOLD < 2) ? 1 : $clog2(FINISH_HOLD + 1);
    // Hold count value at which one more matching PC completes the program.
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(FINISH_HOLD - 1);

    state_t                 r_state;
    logic [c_hold_w-1:0]    r_hold;
    logic [CNT_WIDTH-1:0]   r_cycle;
    logic [CNT_WIDTH-1:0]   r_evt      [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]   w_cycle_nxt;
    logic [CNT_WIDTH-1:0]   w_evt_nxt  [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]   w_sel_val;
    logic                   w_active;
    logic                   w_pc_match;
    logic                   w_finish_hit;
    logic                   w_timeout_hit;

    assign w_active   = (r_state != ST_DONE);
    assign w_pc_match = (pc == c_final_pc);

    // PC completion on this edge: straight from RUN when one matching cycle
    // suffices, otherwise from HOLD once the hold count is one short.
    assign w_finish_hit = w_active && w_pc_match &&
                          (((r_state == ST_RUN) && (FINISH_HOLD <= 1)) ||
                           ((r_state == ST_HOLD) && (r_hold == c_hold_last)));

`ifdef PERF_TIMEOUT_EN
    // Compared at 64 bits so a limit beyond the counter range can never fire.
    localparam logic [63:0] c_to_last = 64'(TIMEOUT_CYCLES) - 64'd1;
    assign w_timeout_hit = w_active && (64'(r_cycle) == c_to_last);
`else
    localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout_hit = 1'b0;
`endif

    // Next counter values: increment while not DONE, saturating at all-ones.
    // On a timeout edge the cycle counter lands on TIMEOUT_CYCLES, which is
    // exactly the ordinary increment.
    always_comb begin
        w_cycle_nxt = r_cycle;
        if (w_active && (r_cycle != '1)) begin
            w_cycle_nxt = r_cycle + CNT_WIDTH'(1);
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_evt_nxt[i] = r_evt[i];
            if (w_active && events[i] && (r_evt[i] != '1)) begin
                w_evt_nxt[i] = r_evt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Readout mux works on next values so count_out shows the post-edge count.
    always_comb begin
        w_sel_val = '0;
        if (sel == 4'd0) begin
            w_sel_val = w_cycle_nxt;
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (sel == 4'(i + 1)) begin
                w_sel_val = w_evt_nxt[i];
            end
        end
    end

    // Counter and readout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            count_out <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_evt[i] <= '0;
            end
        end else begin
            r_cycle   <= w_cycle_nxt;
            count_out <= w_sel_val;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_evt[i] <= w_evt_nxt[i];
            end
        end
    end

    // Completion FSM with registered status outputs; PC finish beats timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_hold      <= '0;
            finished    <= 1'b0;
            timeout     <= 1'b0;
            hold_active <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (w_finish_hit) begin
                        r_state     <= ST_DONE;
                        r_hold      <= '0;
                        finished    <= 1'b1;
                        timeout     <= 1'b0;
                        hold_active <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_DONE;
                        r_hold      <= '0;
                        finished    <= 1'b1;
                        timeout     <= 1'b1;
                        hold_active <= 1'b0;
                    end else if (w_pc_match) begin
                        r_state     <= ST_HOLD;
                        r_hold      <= (r_state == ST_RUN) ? c_hold_w'(1) : r_hold + c_hold_w'(1);
                        hold_active <= 1'b1;
                    end else begin
                        r_state     <= ST_RUN;
                        r_hold      <= '0;
                        hold_active <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_hold      <= '0;
                    finished    <= 1'b0;
                    timeout     <= 1'b0;
                    hold_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_monitor
//  Description : Directed self-checking bench for perf_monitor. Three
//                instances: default widths, 4-bit saturating counters, and a
//                short cycle limit (timeout behaviour depends on
//                PERF_TIMEOUT_EN). Expected values go into a scoreboard queue
//                when stimulus is driven and are popped at each check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_monitor;

    localparam logic [15:0] c_final = 16'h01FF;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk;
    logic rst;

    // main instance
    logic [15:0] m_pc;
    logic [3:0]  m_ev;
    logic [3:0]  m_sel;
    logic [31:0] m_cnt;
    logic        m_fin, m_to, m_hold;
    // saturation instance
    logic [15:0] s_pc;
    logic [3:0]  s_ev;
    logic [3:0]  s_sel;
    logic [3:0]  s_cnt;
    logic        s_fin, s_to, s_hold;
    // timeout instance
    logic [15:0] t_pc;
    logic [3:0]  t_ev;
    logic [3:0]  t_sel;
    logic [7:0]  t_cnt;
    logic        t_fin, t_to, t_hold;

    perf_monitor #(
        .CNT_WIDTH(32), .NUM_EVENTS(4), .PC_WIDTH(16),
        .FINAL_PC(64'h01FF), .FINISH_HOLD(2)
    ) u_main (
        .clk(clk), .rst(rst), .pc(m_pc), .events(m_ev), .sel(m_sel),
        .count_out(m_cnt), .finished(m_fin), .timeout(m_to), .hold_active(m_hold)
    );

    perf_monitor #(
        .CNT_WIDTH(4), .NUM_EVENTS(4), .PC_WIDTH(16),
        .FINAL_PC(64'h01FF), .FINISH_HOLD(2)
    ) u_sat (
        .clk(clk), .rst(rst), .pc(s_pc), .events(s_ev), .sel(s_sel),
        .count_out(s_cnt), .finished(s_fin), .timeout(s_to), .hold_active(s_hold)
    );

    perf_monitor #(
        .CNT_WIDTH(8), .NUM_EVENTS(4), .PC_WIDTH(16),
        .FINAL_PC(64'h01FF), .FINISH_HOLD(2), .TIMEOUT_CYCLES(8)
    ) u_to (
        .clk(clk), .rst(rst), .pc(t_pc), .events(t_ev), .sel(t_sel),
        .count_out(t_cnt), .finished(t_fin), .timeout(t_to), .hold_active(t_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        m_pc  = '0; m_ev = '0; m_sel = '0;
        s_pc  = '0; s_ev = '0; s_sel = '0;
        t_pc  = '0; t_ev = '0; t_sel = '0;

        // Reset state
        push_exp("rst_count", 32'd0);
        push_exp("rst_finished", 32'd0);
        push_exp("rst_timeout", 32'd0);
        push_exp("rst_hold", 32'd0);
        tick();
        chk(m_cnt); chk(32'(m_fin)); chk(32'(m_to)); chk(32'(m_hold));

        // Ten RUN edges with event 0 active
        rst = 1'b0; m_pc = 16'h0000; m_ev = 4'b0001; m_sel = 4'd0;
        push_exp("cycles_10", 32'd10);
        push_exp("run_finished", 32'd0);
        repeat (10) tick();
        chk(m_cnt); chk(32'(m_fin));

        m_ev = 4'b0000; m_sel = 4'd1;
        push_exp("evt0_10", 32'd10);
        tick();
        chk(m_cnt);

        m_sel = 4'd2;
        push_exp("evt1_0", 32'd0);
        tick();
        chk(m_cnt);

        m_sel = 4'd9;
        push_exp("sel_out_of_range", 32'd0);
        push_exp("run_timeout", 32'd0);
        tick();
        chk(m_cnt); chk(32'(m_to));

        // Finish with FINAL_PC at edges 5 and 6
        rst = 1'b1; tick(); rst = 1'b0;
        m_sel = 4'd0; m_ev = 4'b0001; m_pc = 16'h0000;
        repeat (4) tick();
        m_pc = c_final;
        push_exp("hold_edge5", 32'd1);
        push_exp("fin_edge5", 32'd0);
        tick();
        chk(32'(m_hold)); chk(32'(m_fin));
        push_exp("fin_edge6", 32'd1);
        push_exp("hold_edge6", 32'd0);
        push_exp("timeout_edge6", 32'd0);
        push_exp("cycles_at_finish", 32'd6);
        tick();
        chk(32'(m_fin)); chk(32'(m_hold)); chk(32'(m_to)); chk(m_cnt);

        m_pc = 16'h0000; m_sel = 4'd1;
        push_exp("evt0_frozen", 32'd6);
        push_exp("fin_sticky", 32'd1);
        repeat (3) tick();
        chk(m_cnt); chk(32'(m_fin));

        // Reset from DONE
        rst = 1'b1; m_sel = 4'd0; m_ev = 4'b0000;
        push_exp("rst_done_fin", 32'd0);
        push_exp("rst_done_count", 32'd0);
        push_exp("rst_done_hold", 32'd0);
        tick();
        chk(32'(m_fin)); chk(m_cnt); chk(32'(m_hold));
        rst = 1'b0;
        push_exp("after_rst_run", 32'd1);
        push_exp("after_rst_fin", 32'd0);
        tick();
        chk(m_cnt); chk(32'(m_fin));

        // HOLD abort then normal finish
        rst = 1'b1; tick(); rst = 1'b0;
        m_pc = c_final;
        push_exp("abort_hold1", 32'd1);
        tick();
        chk(32'(m_hold));
        m_pc = 16'h0010;
        push_exp("abort_back_run", 32'd0);
        push_exp("abort_not_fin", 32'd0);
        tick();
        chk(32'(m_hold)); chk(32'(m_fin));
        m_pc = c_final;
        push_exp("rehold", 32'd1);
        push_exp("rehold_not_fin", 32'd0);
        tick();
        chk(32'(m_hold)); chk(32'(m_fin));
        push_exp("refinish", 32'd1);
        push_exp("refinish_cycles", 32'd4);
        tick();
        chk(32'(m_fin)); chk(m_cnt);

        // Saturation on 4-bit counters
        rst = 1'b1; tick(); rst = 1'b0;
        s_pc = 16'h0000; s_ev = 4'b1000; s_sel = 4'd4;
        push_exp("sat_evt3", 32'hF);
        repeat (20) tick();
        chk(32'(s_cnt));
        s_sel = 4'd0;
        push_exp("sat_cycles", 32'hF);
        push_exp("sat_not_fin", 32'd0);
        tick();
        chk(32'(s_cnt)); chk(32'(s_fin));
        s_sel = 4'd9;
        push_exp("sat_sel9", 32'd0);
        tick();
        chk(32'(s_cnt));

        // Cycle limit, PC never final
        rst = 1'b1; tick(); rst = 1'b0;
        t_pc = 16'h0000; t_sel = 4'd0;
        push_exp("to_edge7_fin", 32'd0);
        push_exp("to_edge7_cnt", 32'd7);
        repeat (7) tick();
        chk(32'(t_fin)); chk(32'(t_cnt));
`ifdef PERF_TIMEOUT_EN
        push_exp("to_edge8_fin", 32'd1);
        push_exp("to_edge8_timeout", 32'd1);
`else
        push_exp("to_edge8_fin", 32'd0);
        push_exp("to_edge8_timeout", 32'd0);
`endif
        push_exp("to_edge8_cnt", 32'd8);
        tick();
        chk(32'(t_fin)); chk(32'(t_to)); chk(32'(t_cnt));
`ifdef PERF_TIMEOUT_EN
        push_exp("to_frozen_cnt", 32'd8);
`else
        push_exp("to_frozen_cnt", 32'd10);
`endif
        repeat (2) tick();
        chk(32'(t_cnt));

        // Finish and cycle limit on the same edge: finish wins
        rst = 1'b1; tick(); rst = 1'b0;
        t_pc = 16'h0000;
        repeat (6) tick();
        t_pc = c_final;
        push_exp("tie_hold", 32'd1);
        push_exp("tie_edge7_fin", 32'd0);
        tick();
        chk(32'(t_hold)); chk(32'(t_fin));
        push_exp("tie_fin", 32'd1);
        push_exp("tie_timeout", 32'd0);
        push_exp("tie_cnt", 32'd8);
        tick();
        chk(32'(t_fin)); chk(32'(t_to)); chk(32'(t_cnt));

        // Every queued expectation must have been consumed
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
